// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared types, display defaults and colour constants for the pattern generator
package vga_pkg;

   localparam int H_DISPLAY_DEF = 640;
   localparam int V_DISPLAY_DEF = 480;

   typedef logic [11:0] rgb12_t;

   typedef enum logic [1:0] {
      PAT_BARS,
      PAT_CHECKER,
      PAT_BOUNCE,
      PAT_SOLID
   } pattern_mode_t;

   localparam rgb12_t WHITE   = 12'hFFF;
   localparam rgb12_t YELLOW  = 12'hFF0;
   localparam rgb12_t CYAN    = 12'h0FF;
   localparam rgb12_t GREEN   = 12'h0F0;
   localparam rgb12_t MAGENTA = 12'hF0F;
   localparam rgb12_t RED     = 12'hF00;
   localparam rgb12_t BLUE    = 12'h00F;
   localparam rgb12_t BLACK   = 12'h000;

   function automatic rgb12_t bar_color(input logic [2:0] idx);
      rgb12_t c;
      case (idx)
         3'd0:    c = WHITE;
         3'd1:    c = YELLOW;
         3'd2:    c = CYAN;
         3'd3:    c = GREEN;
         3'd4:    c = MAGENTA;
         3'd5:    c = RED;
         3'd6:    c = BLUE;
         default: c = BLACK;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/vga_pattern_gen_if.sv
// rtl/vga_pattern_gen_if.sv - timing-in / pixel-out bundle between the sync generator and the pattern stage
interface vga_pattern_gen_if;
   import vga_pkg::*;

   logic         p_tick;
   logic         video_on;
   logic         hsync_in;
   logic         vsync_in;
   logic [9:0]   x;
   logic [9:0]   y;
   logic [1:0]   mode;
   rgb12_t       solid_color;
   rgb12_t       rgb;
   logic         hsync_out;
   logic         vsync_out;
   logic         frame_tick;
   logic [7:0]   frame_count;

   modport master (
      output p_tick, video_on, hsync_in, vsync_in, x, y, mode, solid_color,
      input  rgb, hsync_out, vsync_out, frame_tick, frame_count
   );

   modport slave (
      input  p_tick, video_on, hsync_in, vsync_in, x, y, mode, solid_color,
      output rgb, hsync_out, vsync_out, frame_tick, frame_count
   );

endinterface

// File: rtl/vga_bounce_box.sv
// rtl/vga_bounce_box.sv - bouncing box position, stepped once per frame and clamped to [0, max]
module vga_bounce_box #(
   parameter int XMAX = 608,
   parameter int YMAX = 448,
   parameter int STEP = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       step_en,
   output logic [9:0] bx,
   output logic [9:0] by
);

   logic dx_pos;
   logic dy_pos;

   // Result bit 10 is the new direction (1 = moving positive); clamping
   // before the add/subtract keeps the position from wrapping.
   function automatic logic [10:0] step_axis(input logic [9:0] pos,
                                             input logic       fwd,
                                             input logic [9:0] lim);
      logic [10:0] r;
      if (fwd) begin
         if ({1'b0, pos} + 11'(STEP) >= {1'b0, lim})
            r = {1'b0, lim};
         else
            r = {1'b1, pos + 10'(STEP)};
      end else begin
         if (pos <= 10'(STEP))
            r = {1'b1, 10'd0};
         else
            r = {1'b0, pos - 10'(STEP)};
      end
      return r;
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bx     <= '0;
         by     <= '0;
         dx_pos <= 1'b1;
         dy_pos <= 1'b1;
      end else if (step_en) begin
         {dx_pos, bx} <= step_axis(bx, dx_pos, 10'(XMAX));
         {dy_pos, by} <= step_axis(by, dy_pos, 10'(YMAX));
      end
   end

endmodule

// File: rtl/vga_pattern_gen.sv
// rtl/vga_pattern_gen.sv - two-stage pixel pipeline producing test patterns with sync re-timed to match
module vga_pattern_gen
   import vga_pkg::*;
#(
   parameter int     H_DISPLAY  = H_DISPLAY_DEF,
   parameter int     V_DISPLAY  = V_DISPLAY_DEF,
   parameter int     BOX_SIZE   = 32,
   parameter int     BOX_STEP   = 2,
   parameter int     CHECK_LOG2 = 5,
   parameter rgb12_t BOX_COLOR  = 12'hF00
) (
   input  logic             clk,
   input  logic             reset,
   vga_pattern_gen_if.slave vid
);

   localparam int BAR_W = H_DISPLAY / 8;

   logic [9:0]    x1, y1;
   logic          von1, hs1, vs1;
   pattern_mode_t mode_q;
   rgb12_t        rgb_q;
   logic          hs2, vs2;
   logic          ftick_q;
   logic [7:0]    fcount_q;
   logic [9:0]    bx, by;
   logic          frame_start;
   rgb12_t        colour;
   logic [2:0]    bar_idx;
   logic          in_box;

   // vs1 holds the previous sampled vsync, so this is a rising-edge detect
   assign frame_start = vid.p_tick & vid.vsync_in & ~vs1;

   vga_bounce_box #(
      .XMAX (H_DISPLAY - BOX_SIZE),
      .YMAX (V_DISPLAY - BOX_SIZE),
      .STEP (BOX_STEP)
   ) u_box (
      .clk     (clk),
      .reset   (reset),
      .step_en (frame_start),
      .bx      (bx),
      .by      (by)
   );

   // Bar index by threshold compares; the smallest matching threshold wins
   always_comb begin
      bar_idx = 3'd7;
      for (int i = 6; i >= 0; i--) begin
         if ({22'd0, x1} < 32'((i + 1) * BAR_W))
            bar_idx = 3'(i);
      end
   end

   always_comb begin
      in_box = ({1'b0, x1} >= {1'b0, bx}) && ({1'b0, x1} < {1'b0, bx} + 11'(BOX_SIZE)) &&
               ({1'b0, y1} >= {1'b0, by}) && ({1'b0, y1} < {1'b0, by} + 11'(BOX_SIZE));
   end

   always_comb begin
      colour = BLACK;
      case (mode_q)
         PAT_BARS:    colour = bar_color(bar_idx);
         PAT_CHECKER: colour = (x1[CHECK_LOG2] ^ y1[CHECK_LOG2]) ? BLACK : WHITE;
         PAT_BOUNCE:  colour = in_box ? BOX_COLOR : BLACK;
         PAT_SOLID:   colour = vid.solid_color;
         default:     colour = BLACK;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x1       <= '0;
         y1       <= '0;
         von1     <= 1'b0;
         hs1      <= 1'b0;
         vs1      <= 1'b0;
         mode_q   <= PAT_BARS;
         rgb_q    <= BLACK;
         hs2      <= 1'b0;
         vs2      <= 1'b0;
         ftick_q  <= 1'b0;
         fcount_q <= '0;
      end else if (vid.p_tick) begin
         x1      <= vid.x;
         y1      <= vid.y;
         von1    <= vid.video_on;
         hs1     <= vid.hsync_in;
         vs1     <= vid.vsync_in;
         rgb_q   <= von1 ? colour : BLACK;
         hs2     <= hs1;
         vs2     <= vs1;
         ftick_q <= frame_start;
         if (frame_start) begin
            fcount_q <= fcount_q + 8'd1;
            mode_q   <= pattern_mode_t'(vid.mode);
         end
      end else begin
         ftick_q <= 1'b0;
      end
   end

   assign vid.rgb         = rgb_q;
   assign vid.hsync_out   = hs2;
   assign vid.vsync_out   = vs2;
   assign vid.frame_tick  = ftick_q;
   assign vid.frame_count = fcount_q;

endmodule

// File: doc/vga_pattern_gen.md
Name: vga_pattern_gen

Overview:
- Pixel-generation stage directly downstream of the VGA sync/timing generator.
- Consumes the timing generator's outputs: pixel tick, x/y position, video_on, hsync, vsync.
- Produces 12-bit RGB (4:4:4) plus hsync/vsync re-timed to match the RGB pipeline delay.
- Four mode-selectable test patterns, including a bouncing box animated once per frame; intended for board bring-up and monitor checks.

Parameters:
- H_DISPLAY, 640, visible pixels per line.
- V_DISPLAY, 480, visible lines per frame.
- BOX_SIZE, 32, bouncing box edge length in pixels.
- BOX_STEP, 2, box displacement per frame on each axis, in pixels.
- CHECK_LOG2, 5, log2 of checkerboard square size (32 px).
- BOX_COLOR, 12'hF00, box colour in mode 2.

Ports:
- clk  in  1  system clock (4x pixel rate).
- reset  in  1  asynchronous, active-high.
- p_tick  in  1  one-clk pixel enable from the timing generator.
- video_on  in  1  high while x/y is in the visible area.
- hsync_in  in  1  horizontal sync, high during retrace.
- vsync_in  in  1  vertical sync, high during retrace.
- x  in  10  current pixel column.
- y  in  10  current pixel row.
- mode  in  2  pattern select: 0 bars, 1 checker, 2 bounce, 3 solid.
- solid_color  in  12  colour for mode 3.
- rgb  out  12  pixel colour, {R[3:0],G[3:0],B[3:0]}.
- hsync_out  out  1  hsync_in delayed to align with rgb; polarity unchanged.
- vsync_out  out  1  vsync_in delayed to align with rgb; polarity unchanged.
- frame_tick  out  1  one-clk pulse at each frame start.
- frame_count  out  8  frames since reset; wraps 255->0.

Behaviour:
- Clock and reset: clk, reset asynchronous active-high (already decided).
- Reset values: all registers and outputs are 0, except the box velocities, which reset to positive. Box position (0,0).
- Input sampling: all registers advance only in clk cycles where p_tick=1. Inputs are stable and mutually aligned in those cycles.
- Pipeline: two p_tick stages.
  - S1 registers x, y, video_on, hsync_in, vsync_in.
  - S2 computes the colour from S1 values and registers rgb, hsync_out, vsync_out.
  - Total latency is 2 p_ticks; sync outputs carry the identical 2-tick delay.
- Blanking: if S1 video_on=0, rgb=0 regardless of mode.
- Frame start: detected when vsync_in is sampled high at a p_tick and its previous sampled value was low (rising edge).
  - On that tick: frame_tick=1 for exactly one clk; frame_count increments; active mode is updated from the mode port; box state updates.
- Mode latching: a mode change mid-frame has no effect until the next frame start, so there is no tearing. The active mode resets to 0.
- Mode 0 (colour bars): 8 bars of H_DISPLAY/8 = 80 px, selected by compare thresholds (no divider). Left to right: FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000.
- Mode 1 (checkerboard): x[CHECK_LOG2] ^ y[CHECK_LOG2] = 0 gives FFF, otherwise 000.
- Mode 2 (bounce): BOX_COLOR when bx <= x < bx+BOX_SIZE and by <= y < by+BOX_SIZE, else 000. Compares are 11-bit to avoid overflow.
- Mode 3 (solid): solid_color, sampled at S2.
- Box update, at frame start, independent of active mode:
  - Limits: XMAX = H_DISPLAY-BOX_SIZE = 608, YMAX = V_DISPLAY-BOX_SIZE = 448.
  - Moving positive: if bx+BOX_STEP >= XMAX, then bx=XMAX and the direction flips; otherwise bx += BOX_STEP.
  - Moving negative: if bx <= BOX_STEP, then bx=0 and the direction flips; otherwise bx -= BOX_STEP.
  - The y axis is identical, using YMAX.
  - Position never leaves [0, MAX]; no unsigned underflow.
- Reset mid-frame: all state returns to reset values at once. Outputs are 0 until the pipeline refills (2 p_ticks after reset release).
- p_tick low: all registers hold; frame_tick stays 0.

Decomposition:
- vga_pkg holds:
  - H_DISPLAY/V_DISPLAY defaults;
  - rgb12_t typedef (logic [11:0]);
  - enum pattern_mode_t {PAT_BARS, PAT_CHECKER, PAT_BOUNCE, PAT_SOLID};
  - named colour constants: WHITE, YELLOW, CYAN, GREEN, MAGENTA, RED, BLUE, BLACK.
- Sub-module vga_bounce_box:
  - Inputs: clk, reset, step_en (frame start).
  - Outputs: bx, by.
  - Holds position and direction registers and the clamp/flip logic.
- Top level holds the input pipeline, edge detect, frame counter, mode latch and colour mux.

Test Plan:
- Reset, mode=0, drive x=0,y=0,video_on=1 at p_tick -> rgb=FFF 2 p_ticks later. x=80 -> FF0; x=639 -> 000. hsync_out/vsync_out equal hsync_in/vsync_in delayed exactly 2 p_ticks.
- video_on=0 with mode 3, solid_color=ABC -> rgb=000. video_on=1 -> rgb=ABC.
- Mode 1: (x=0,y=0) -> FFF; (32,0) -> 000; (32,32) -> FFF.
- Bounce: 1 vsync rising edge -> bx=2, by=2, frame_tick one clk, frame_count=1. After 304 frames -> bx=608 with direction flipped; next frame -> bx=606. By=448 at frame 224; by=446 at frame 225.
- Change mode from 0 to 1 mid-frame -> bars persist until the next vsync rising edge, checker after it. vsync held high for 2 lines -> exactly one frame_tick.
- Assert reset mid-frame with box at (100,100) -> rgb/syncs/frame_count=0 immediately. After release the box restarts at (0,0) moving positive.
